// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 op codes and FSM states.
package ex_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mdu_sign_unit.sv
// Combinational sign handling for ex_muldiv: operand magnitudes and fast-path detection at
// accept time, and sign correction / half selection of the raw iteration result at finish.
module mdu_sign_unit
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [XLEN-1:0] mag1_o,
  output logic [XLEN-1:0] mag2_o,
  output logic            neg_main_o,
  output logic            neg_rem_o,
  output logic            fast_o,
  output logic [XLEN-1:0] fast_res_o,
  input  logic [2:0]      fin_op_i,
  input  logic            fin_neg_main_i,
  input  logic            fin_neg_rem_i,
  input  logic [XLEN-1:0] fin_hi_i,
  input  logic [XLEN-1:0] fin_lo_i,
  output logic [XLEN-1:0] fin_res_o
);

  logic              sgn1, sgn2;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   min_neg;
  logic [2*XLEN-1:0] prod_raw, prod_fix;

  always_comb begin
    min_neg = '0;
    min_neg[XLEN-1] = 1'b1;
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    unique case (op_i)
      OP_MULH, OP_DIV, OP_REM: begin
        sgn1 = rs1_i[XLEN-1];
        sgn2 = rs2_i[XLEN-1];
      end
      OP_MULHSU: sgn1 = rs1_i[XLEN-1];
      default: ;
    endcase
    mag1_o     = sgn1 ? (~rs1_i + 1'b1) : rs1_i;
    mag2_o     = sgn2 ? (~rs2_i + 1'b1) : rs2_i;
    neg_main_o = sgn1 ^ sgn2;
    neg_rem_o  = sgn1;

    div_zero = op_i[2] && (rs2_i == '0);
    div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) && (rs1_i == min_neg) && (rs2_i == '1);
    fast_o   = div_zero || div_ovf;
    // op[1] distinguishes REM* from DIV*
    if (div_zero)
      fast_res_o = op_i[1] ? rs1_i : '1;
    else
      fast_res_o = op_i[1] ? '0 : rs1_i;
  end

  always_comb begin
    prod_raw = {fin_hi_i, fin_lo_i};
    prod_fix = fin_neg_main_i ? (~prod_raw + 1'b1) : prod_raw;
    unique case (fin_op_i)
      OP_MUL:                      fin_res_o = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res_o = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fin_res_o = fin_neg_main_i ? (~fin_lo_i + 1'b1) : fin_lo_i;
      default:                     fin_res_o = fin_neg_rem_i ? (~fin_hi_i + 1'b1) : fin_hi_i;
    endcase
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M-style multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// one step per cycle, with single-cycle fast paths for divide-by-zero and signed overflow.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned TAGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [TAGW-1:0] tag_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [TAGW-1:0] tag_out,
  output logic            busy
);

  localparam int unsigned CNTW = $clog2(XLEN) + 1;
  localparam logic [CNTW-1:0] LAST_STEP = CNTW'(XLEN - 1);

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [TAGW-1:0] tag_req_q, tag_req_d;
  logic [TAGW-1:0] tag_out_q, tag_out_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic            neg_main_q, neg_main_d, neg_rem_q, neg_rem_d;

  logic [XLEN-1:0] mag1, mag2, fast_res, fin_res;
  logic            neg_main, neg_rem, fast;

  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] hi_step, lo_step;

  mdu_sign_unit #(.XLEN(XLEN)) u_sign (
    .op_i          (op),
    .rs1_i         (rs1),
    .rs2_i         (rs2),
    .mag1_o        (mag1),
    .mag2_o        (mag2),
    .neg_main_o    (neg_main),
    .neg_rem_o     (neg_rem),
    .fast_o        (fast),
    .fast_res_o    (fast_res),
    .fin_op_i      (op_q),
    .fin_neg_main_i(neg_main_q),
    .fin_neg_rem_i (neg_rem_q),
    .fin_hi_i      (hi_step),
    .fin_lo_i      (lo_step),
    .fin_res_o     (fin_res)
  );

  // hi/lo form one shift register: {partial product, multiplier} for MUL*,
  // {partial remainder, dividend->quotient} for DIV*/REM*.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = ~div_diff[XLEN];
    if (!op_q[2]) begin
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
    end else begin
      hi_step = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      lo_step = {lo_q[XLEN-2:0], div_ge};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    tag_req_d   = tag_req_q;
    tag_out_d   = tag_out_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opnd_d      = opnd_q;
    neg_main_d  = neg_main_q;
    neg_rem_d   = neg_rem_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          op_d       = op;
          tag_req_d  = tag_in;
          neg_main_d = neg_main;
          neg_rem_d  = neg_rem;
          cnt_d      = '0;
          hi_d       = '0;
          lo_d       = op[2] ? mag1 : mag2;
          opnd_d     = op[2] ? mag2 : mag1;
          if (fast) begin
            result_d    = fast_res;
            tag_out_d   = tag_in;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          hi_d  = hi_step;
          lo_d  = lo_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            result_d    = fin_res;
            tag_out_d   = tag_req_q;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (flush || out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      tag_req_q   <= '0;
      tag_out_q   <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      neg_main_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      tag_req_q   <= tag_req_d;
      tag_out_q   <= tag_out_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opnd_q      <= opnd_d;
      neg_main_q  <= neg_main_d;
      neg_rem_q   <= neg_rem_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign tag_out   = tag_out_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv (XLEN=32): arithmetic, latency, backpressure, flush and reset.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [4:0]  tag_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  tag_out;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  ex_muldiv #(.XLEN(32), .TAGW(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .rs1      (rs1),
    .rs2      (rs2),
    .tag_in   (tag_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .tag_out  (tag_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Presents one request; lat = edges after the accepting edge until out_valid is seen
  // (0 when the accepting edge itself registers the result), -1 on timeout.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, output logic [31:0] res, output logic [4:0] tg,
                        output int lat);
    @(negedge clk);
    in_valid = 1'b1; op = o; rs1 = a; rs2 = b; tag_in = t;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    if (out_valid) lat = 0;
    for (int k = 1; k <= 200 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (out_valid) lat = k;
    end
    res = result;
    tg  = tag_out;
  endtask

  task automatic consume();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, busy, in_ready} !== 3'b001 || result !== 32'h0 || tag_out !== 5'h0) begin
      n_bad++;
      $display("FAIL reset: valid/busy/ready=%b result=%h tag=%h, required 001/0/0",
               {out_valid, busy, in_ready}, result, tag_out);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [31:0] r; logic [4:0] tg; int lat;
    run_op(OP_MUL, 32'd7, 32'hFFFFFFFD, 5'h13, r, tg, lat);
    n_cmp++;
    if (r !== 32'hFFFFFFEB) begin n_bad++; $display("FAIL mul_result: got %h, required ffffffeb", r); end
    n_cmp++;
    if (lat !== 32) begin n_bad++; $display("FAIL mul_latency: got %0d, required 32", lat); end
    n_cmp++;
    if (tg !== 5'h13) begin n_bad++; $display("FAIL mul_tag: got %h, required 13", tg); end
    consume();
  endtask

  task automatic test_mulh();
    logic [31:0] r; logic [4:0] tg; int lat;
    run_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h01, r, tg, lat);
    n_cmp++;
    if (r !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL mulhu: got %h, required fffffffe", r); end
    consume();
    run_op(OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h02, r, tg, lat);
    n_cmp++;
    if (r !== 32'h00000000) begin n_bad++; $display("FAIL mulh_neg: got %h, required 00000000", r); end
    consume();
    run_op(OP_MULHSU, 32'hFFFFFFFF, 32'd2, 5'h03, r, tg, lat);
    n_cmp++;
    if (r !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mulhsu: got %h, required ffffffff", r); end
    consume();
    run_op(OP_MULH, 32'h80000000, 32'h80000000, 5'h04, r, tg, lat);
    n_cmp++;
    if (r !== 32'h40000000) begin n_bad++; $display("FAIL mulh_minneg: got %h, required 40000000", r); end
    consume();
  endtask

  task automatic test_div();
    logic [31:0] r; logic [4:0] tg; int lat;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 5'h05, r, tg, lat);
    n_cmp++;
    if (r !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_neg: got %h, required fffffffd", r); end
    n_cmp++;
    if (lat !== 32) begin n_bad++; $display("FAIL div_latency: got %0d, required 32", lat); end
    consume();
    run_op(OP_REM, 32'hFFFFFFF9, 32'd2, 5'h06, r, tg, lat);
    n_cmp++;
    if (r !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL rem_neg: got %h, required ffffffff", r); end
    consume();
    run_op(OP_REM, 32'd7, 32'hFFFFFFFE, 5'h07, r, tg, lat);
    n_cmp++;
    if (r !== 32'h00000001) begin n_bad++; $display("FAIL rem_negdivisor: got %h, required 00000001", r); end
    consume();
    run_op(OP_DIVU, 32'd100, 32'd7, 5'h08, r, tg, lat);
    n_cmp++;
    if (r !== 32'd14) begin n_bad++; $display("FAIL divu: got %h, required 0000000e", r); end
    consume();
    run_op(OP_REMU, 32'd100, 32'd7, 5'h09, r, tg, lat);
    n_cmp++;
    if (r !== 32'd2) begin n_bad++; $display("FAIL remu: got %h, required 00000002", r); end
    consume();
  endtask

  task automatic test_fast_path();
    logic [31:0] r; logic [4:0] tg; int lat;
    run_op(OP_DIVU, 32'd100, 32'd0, 5'h0A, r, tg, lat);
    n_cmp++;
    if (r !== 32'hFFFFFFFF || lat !== 0) begin
      n_bad++; $display("FAIL divu_by_zero: got %h lat %0d, required ffffffff lat 0", r, lat);
    end
    consume();
    run_op(OP_REMU, 32'd100, 32'd0, 5'h0B, r, tg, lat);
    n_cmp++;
    if (r !== 32'd100 || lat !== 0 || tg !== 5'h0B) begin
      n_bad++; $display("FAIL remu_by_zero: got %h lat %0d tag %h, required 00000064 lat 0 tag 0b", r, lat, tg);
    end
    consume();
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'h0C, r, tg, lat);
    n_cmp++;
    if (r !== 32'h80000000 || lat !== 0) begin
      n_bad++; $display("FAIL div_overflow: got %h lat %0d, required 80000000 lat 0", r, lat);
    end
    consume();
    run_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'h0D, r, tg, lat);
    n_cmp++;
    if (r !== 32'h00000000 || lat !== 0) begin
      n_bad++; $display("FAIL rem_overflow: got %h lat %0d, required 00000000 lat 0", r, lat);
    end
    consume();
  endtask

  task automatic test_backpressure();
    logic [31:0] r; logic [4:0] tg; int lat;
    run_op(OP_DIVU, 32'd100, 32'd7, 5'h11, r, tg, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd14 || tag_out !== 5'h11) begin
        n_bad++;
        $display("FAIL hold_%0d: valid=%b ready=%b result=%h tag=%h, required 1/0/0000000e/11",
                 i, out_valid, in_ready, result, tag_out);
      end
    end
    consume();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL release: ready=%b valid=%b busy=%b, required 1/0/0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_flush();
    bit seen;
    logic [31:0] r; logic [4:0] tg; int lat;
    @(negedge clk);
    in_valid = 1'b1; op = OP_DIVU; rs1 = 32'd5000; rs2 = 32'd3; tag_in = 5'h15;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_calc: ready=%b busy=%b valid=%b, required 1/0/0", in_ready, busy, out_valid);
    end
    n_cmp++;
    if (result !== 32'd14 || tag_out !== 5'h11) begin
      n_bad++; $display("FAIL flush_retain: result=%h tag=%h, required 0000000e/11", result, tag_out);
    end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL flush_no_valid: out_valid rose=%b, required 0", seen); end

    run_op(OP_DIVU, 32'd9, 32'd3, 5'h16, r, tg, lat);
    @(negedge clk); flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; flush = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_done: ready=%b valid=%b, required 1/0", in_ready, out_valid);
    end

    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = OP_DIVU; rs1 = 32'd1; rs2 = 32'd0;
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_idle_accept: busy=%b valid=%b, required 0/0", busy, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    logic [31:0] r;
    int lat;
    @(negedge clk);
    in_valid = 1'b1; op = OP_MUL; rs1 = 32'd3; rs2 = 32'd5; tag_in = 5'h1A;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL b2b_ready: ready=%b busy=%b, required 0/1", in_ready, busy);
    end
    @(posedge clk); #1; in_valid = 1'b0;
    lat = -1;
    for (int k = 2; k <= 200 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (out_valid) lat = k;
    end
    r = result;
    n_cmp++;
    if (r !== 32'd15 || lat !== 32) begin
      n_bad++; $display("FAIL b2b_result: got %h lat %0d, required 0000000f lat 32", r, lat);
    end
    consume();
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL b2b_single: second result=%b, required 0", seen); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    in_valid = 1'b1; op = OP_MUL; rs1 = 32'd9; rs2 = 32'd9; tag_in = 5'h1F;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, busy, in_ready} !== 3'b001 || result !== 32'h0 || tag_out !== 5'h0) begin
      n_bad++;
      $display("FAIL reset_mid: valid/busy/ready=%b result=%h tag=%h, required 001/0/0",
               {out_valid, busy, in_ready}, result, tag_out);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid || busy) seen = 1'b1; end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL reset_abandon: activity=%b, required 0", seen); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_fast_path();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter XLEN, default 32, operand/result width in bits; SHALL support any XLEN >= 8.
REQ-002 Parameter TAGW, default 5, width of the destination-register tag carried through the unit.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  abort any operation in progress; pipeline kill from the hazard unit.
REQ-006 in_valid  input  1  request present on op/rs1/rs2/tag_in.
REQ-007 in_ready  output  1  unit can accept a request this cycle.
REQ-008 op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-009 rs1, rs2  input  XLEN each  source operands (dividend/multiplicand, divisor/multiplier).
REQ-010 tag_in  input  TAGW  destination tag captured with the request.
REQ-011 out_valid  output  1  result and tag_out are valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 result  output  XLEN  registered operation result.
REQ-014 tag_out  output  TAGW  tag of the request that produced result.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, CALC and DONE; in_ready SHALL equal (state == IDLE); no back-to-back acceptance.
REQ-017 Accept SHALL occur on an edge where in_valid && in_ready && !flush; operands, op and tag SHALL be registered on that edge.
REQ-018 Normal path: IDLE->CALC on accept, one radix-2 shift-add (MUL*) or restoring shift-subtract (DIV*/REM*) step per CALC edge, step counter width clog2(XLEN)+1, CALC->DONE on the XLEN-th step edge.
REQ-019 out_valid SHALL rise exactly XLEN edges after the accepting edge on the normal path.
REQ-020 Signed ops SHALL iterate on operand magnitudes; sign correction SHALL be applied before result is registered at CALC->DONE.
REQ-021 MUL returns product[XLEN-1:0]; MULH signed x signed high half; MULHSU signed rs1 x unsigned rs2 high half; MULHU unsigned high half.
REQ-022 DIV/REM SHALL truncate toward zero; remainder sign SHALL equal dividend sign.
REQ-023 Fast path, divide by zero: quotient all-ones, remainder = rs1; IDLE->DONE on the accepting edge, out_valid one edge after accept.
REQ-024 Fast path, signed overflow (rs1 = most-negative, rs2 = all-ones, DIV/REM): quotient = rs1, remainder = 0; one-edge latency as REQ-023.
REQ-025 DONE SHALL hold result, tag_out, out_valid stable until out_valid && out_ready, then return to IDLE on that edge.
REQ-026 flush SHALL force IDLE on the next edge from any state, deassert out_valid, and discard the result; flush with in_valid in IDLE SHALL not accept.
REQ-027 flush coincident with out_ready in DONE: the handshake is considered complete; the next state is IDLE either way.
REQ-028 result and tag_out SHALL retain their last value in IDLE and CALC (not qualified without out_valid).

Reset
REQ-029 While rst_n low: state IDLE, counter 0, out_valid 0, result 0, tag_out 0, busy 0, in_ready 1, all operand/accumulator registers 0.
REQ-030 Reset assertion mid-CALC or mid-DONE SHALL abandon the operation with no output handshake after release.

Structure
REQ-031 Package ex_muldiv_pkg SHALL hold the op encodings (localparams) and the FSM state enum; the top SHALL import it.
REQ-032 One sub-module, mdu_sign_unit (combinational: operand magnitude, result negation, fast-path detection), SHALL be instantiated once; the datapath iteration and FSM SHALL stay in ex_muldiv.

Verification (XLEN=32)
REQ-033 MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid exactly 32 edges after accept.
REQ-034 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-035 DIV -7/2 -> 0xFFFFFFFD; REM -7%2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100, each with 1-edge latency.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM same -> 0, 1-edge latency.
REQ-037 Hold out_ready low 5 cycles in DONE -> result/tag_out/out_valid stable, in_ready 0; raise out_ready -> IDLE next edge.
REQ-038 flush at CALC step 10 of a DIVU -> out_valid never rises, in_ready 1 next cycle; rst_n pulse mid-CALC -> all outputs at REQ-029 values immediately.
